// File: rtl/cpu_to_tx_data_splitter.sv
// Buffers 16-bit CPU words in a small FIFO and feeds them to the UART TX
// one byte at a time, MSB first, using a start/done handshake.
module cpu_to_tx_data_splitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      cpu_data,
  input  logic             cpu_valid,
  output logic             cpu_ready,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    SEND_MSB,
    WAIT_MSB,
    SEND_LSB,
    WAIT_LSB
  } state_t;

  logic [15:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  logic             overflow_q;
  state_t           state_q;
  logic [15:0]      hold_q;
  logic [7:0]       tx_data_q;
  logic             tx_start_q;
  logic             push, pop;

  // Ready comes from the registered count, so a full FIFO rejects a write
  // even when a pop happens on the same edge.
  assign push = cpu_valid && ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0) && !tx_busy;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cpu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
      if (cpu_valid && !ready_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // tx_start and tx_data are loaded on the edge that enters a SEND state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_q     <= mem_q[rd_ptr_q];
            tx_data_q  <= mem_q[rd_ptr_q][15:8];
            tx_start_q <= 1'b1;
            state_q    <= SEND_MSB;
          end
        end
        SEND_MSB: state_q <= WAIT_MSB;
        WAIT_MSB: begin
          if (tx_done) begin
            tx_data_q  <= hold_q[7:0];
            tx_start_q <= 1'b1;
            state_q    <= SEND_LSB;
          end
        end
        SEND_LSB: state_q <= WAIT_LSB;
        WAIT_LSB: begin
          if (tx_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready  = ready_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_cpu_to_tx_data_splitter.sv
// Bench for cpu_to_tx_data_splitter: a UART TX model checks every byte
// against a scoreboard queue filled as words are pushed.
module tb_cpu_to_tx_data_splitter;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int TX_DELAY   = 10;

  logic             clk;
  logic             reset;
  logic [15:0]      cpu_data;
  logic             cpu_valid;
  logic             cpu_ready;
  logic [7:0]       tx_data;
  logic             tx_start;
  logic             tx_busy;
  logic             tx_done;
  logic [CNT_W-1:0] fifo_count;
  logic             busy;
  logic             overflow;

  logic modelDone;
  logic manualDone;
  bit   autoDone;
  int   doneCnt;
  int   startCount;
  int   checks;
  int   failures;
  logic [7:0] expQ[$];

  typedef struct {
    logic [15:0] word;
    logic [7:0]  expMsb;
    logic [7:0]  expLsb;
  } vec_t;

  vec_t vecs[4];

  assign tx_done = modelDone | manualDone;

  cpu_to_tx_data_splitter #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_data(cpu_data),
    .cpu_valid(cpu_valid),
    .cpu_ready(cpu_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .fifo_count(fifo_count),
    .busy(busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // UART TX model: checks each started byte and optionally answers with tx_done.
  always @(negedge clk) begin
    modelDone = 1'b0;
    if (doneCnt > 0) begin
      doneCnt--;
      if (doneCnt == 0) modelDone = 1'b1;
    end
    if (tx_start === 1'b1) begin
      startCount++;
      if (expQ.size() != 0) checkOutput("txByte", tx_data, expQ.pop_front());
      else checkOutput("unexpectedStart", tx_start, 0);
      if (autoDone) doneCnt = TX_DELAY;
    end
  end

  task automatic applyStimulus(input logic [15:0] word, input logic [7:0] msb,
                               input logic [7:0] lsb, input int nExp);
    if (nExp > 0) expQ.push_back(msb);
    if (nExp > 1) expQ.push_back(lsb);
    cpu_data  = word;
    cpu_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
  endtask

  task automatic pulseDone();
    manualDone = 1'b1;
    @(negedge clk);
    manualDone = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idleTimeout", busy, 0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset      = 1'b0;
    cpu_valid  = 1'b0;
    tx_busy    = 1'b0;
    manualDone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    expQ.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0;
    checks     = 0;
    failures   = 0;
    startCount = 0;
    doneCnt    = 0;
    autoDone   = 1'b1;
    modelDone  = 1'b0;
    manualDone = 1'b0;
    cpu_data   = '0;
    cpu_valid  = 1'b0;
    tx_busy    = 1'b0;
    reset      = 1'b0;

    vecs[0] = '{16'hA55A, 8'hA5, 8'h5A};
    vecs[1] = '{16'h1234, 8'h12, 8'h34};
    vecs[2] = '{16'hFF00, 8'hFF, 8'h00};
    vecs[3] = '{16'h00FF, 8'h00, 8'hFF};

    repeat (2) @(negedge clk);
    checkOutput("rstReady", cpu_ready, 1);
    checkOutput("rstTxData", tx_data, 8'h00);
    checkOutput("rstTxStart", tx_start, 0);
    checkOutput("rstCount", fifo_count, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstOverflow", overflow, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single words through an idle TX, including first-start latency.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].word, vecs[i].expMsb, vecs[i].expLsb, 2);
      checkOutput("pushCount", fifo_count, 1);
      checkOutput("noEarlyStart", tx_start, 0);
      @(negedge clk);
      checkOutput("msbStart", tx_start, 1);
      checkOutput("popCount", fifo_count, 0);
      waitIdle(100);
      checkOutput("idleCount", fifo_count, 0);
      checkOutput("idleQueue", expQ.size(), 0);
    end

    // Burst fill with the TX stalled, then one write while full.
    autoDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [15:0] w;
      w = {8'(2 * i + 1), 8'(2 * i + 2)};
      applyStimulus(w, w[15:8], w[7:0], 2);
    end
    checkOutput("burstCount", fifo_count, 4);
    checkOutput("burstReady", cpu_ready, 0);
    checkOutput("burstNoOvf", overflow, 0);
    applyStimulus(16'h0B0C, 8'h0B, 8'h0C, 0);
    checkOutput("fullOvf", overflow, 1);
    checkOutput("fullCount", fifo_count, 4);
    autoDone = 1'b1;
    pulseDone();
    waitIdle(400);
    checkOutput("ovfSticky", overflow, 1);
    checkOutput("burstQueue", expQ.size(), 0);
    resetDut();
    checkOutput("ovfCleared", overflow, 0);

    // tx_busy gating, then a push on the pop edge while full.
    tx_busy = 1'b1;
    s0 = startCount;
    applyStimulus(16'h1111, 8'h11, 8'h11, 2);
    applyStimulus(16'h2222, 8'h22, 8'h22, 2);
    applyStimulus(16'h3333, 8'h33, 8'h33, 2);
    applyStimulus(16'h4444, 8'h44, 8'h44, 2);
    repeat (5) @(negedge clk);
    checkOutput("gatedStarts", startCount - s0, 0);
    checkOutput("gatedCount", fifo_count, 4);
    checkOutput("gatedBusy", busy, 1);
    tx_busy   = 1'b0;
    cpu_data  = 16'h5555;
    cpu_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    checkOutput("pushPopCount", fifo_count, 3);
    checkOutput("pushPopOvf", overflow, 1);
    checkOutput("ungatedStart", tx_start, 1);
    waitIdle(400);
    checkOutput("gatedQueue", expQ.size(), 0);
    resetDut();

    // Spurious tx_done in IDLE and SEND_MSB.
    s0 = startCount;
    pulseDone();
    repeat (3) @(negedge clk);
    checkOutput("idleDoneStarts", startCount - s0, 0);
    checkOutput("idleDoneBusy", busy, 0);
    autoDone = 1'b0;
    applyStimulus(16'h7788, 8'h77, 8'h88, 2);
    @(negedge clk);
    checkOutput("sendMsbStart", tx_start, 1);
    pulseDone();
    repeat (5) @(negedge clk);
    checkOutput("sendDoneStarts", startCount - s0, 1);
    checkOutput("sendDoneBusy", busy, 1);
    autoDone = 1'b1;
    pulseDone();
    waitIdle(100);
    checkOutput("spuriousStarts", startCount - s0, 2);

    // Reset in WAIT_MSB with two words queued.
    autoDone = 1'b0;
    applyStimulus(16'hABCD, 8'hAB, 8'hCD, 1);
    applyStimulus(16'h1357, 8'h13, 8'h57, 0);
    applyStimulus(16'h2468, 8'h24, 8'h68, 0);
    checkOutput("midCount", fifo_count, 2);
    repeat (2) @(negedge clk);
    s0 = startCount;
    reset = 1'b0;
    #1;
    checkOutput("midRstStart", tx_start, 0);
    checkOutput("midRstCount", fifo_count, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstReady", cpu_ready, 1);
    checkOutput("midRstData", tx_data, 8'h00);
    @(negedge clk);
    reset    = 1'b1;
    autoDone = 1'b1;
    pulseDone();
    repeat (30) @(negedge clk);
    checkOutput("noLsbAfterRst", startCount - s0, 0);
    checkOutput("postRstBusy", busy, 0);
    checkOutput("postRstQueue", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
